// File: rtl/jtag_dmi_host.sv
// jtag_dmi_host: JTAG host that performs one IR scan followed by one DR scan
// per request and returns the TDO bits captured during the DR shift.
//
// Ports:
//   clk_i, trst_ni           system clock, async active-low reset
//   req_valid_i/req_ready_o  request handshake; req_ir_i, req_dr_i, req_len_i
//                            are latched on acceptance
//   rsp_valid_o/rsp_ready_i  response handshake; rsp_dr_o holds captured TDO
//   tck_o, tms_o, tdi_o      to the target TAP; tdo_i from the target TAP
//
// Optional feature: define JTAG_DMI_HOST_IR_CACHE_EN to skip the IR scan when
// the requested instruction equals the last one shifted.
`timescale 1ns/1ps

module jtag_dmi_host #(
    parameter int unsigned IrLength = 5,
    parameter int unsigned DrMaxLen = 41,
    parameter int unsigned ClkDiv   = 2
) (
    input  logic                clk_i,
    input  logic                trst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [IrLength-1:0] req_ir_i,
    input  logic [DrMaxLen-1:0] req_dr_i,
    input  logic [5:0]          req_len_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DrMaxLen-1:0] rsp_dr_o,
    output logic                tck_o,
    output logic                tms_o,
    output logic                tdi_o,
    input  logic                tdo_i
);

    typedef enum logic [3:0] {
        INIT, IDLE, SEL_DR_IR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, UPD_IR,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, UPD_DR, RESP
    } state_e;

    localparam int unsigned     DivW     = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [DivW-1:0] DivLast  = DivW'(ClkDiv - 1);
    localparam logic [5:0]      IrLast   = 6'(IrLength - 1);
    localparam logic [5:0]      DrMax    = 6'(DrMaxLen);
    localparam logic [5:0]      InitLast = 6'd5;
    localparam logic [DrMaxLen-1:0] MaskLsb = DrMaxLen'(1);

    state_e              state_q;
    logic                run_q;      // TCK generator enabled
    logic [DivW-1:0]     div_q;
    logic [5:0]          cnt_q;
    logic [IrLength-1:0] ir_q;
    logic [IrLength-1:0] ir_sh;
    logic [DrMaxLen-1:0] dr_q;
    logic [5:0]          len_q;
    logic [DrMaxLen-1:0] mask_q;     // one-hot position of the next TDO sample
    logic [5:0]          len_clamped;
    logic                tick;
    logic                ir_hit;

    always_comb begin
        len_clamped = req_len_i;
        if (req_len_i == 6'd0) begin
            len_clamped = 6'd1;
        end else if (req_len_i > DrMax) begin
            len_clamped = DrMax;
        end
    end

    assign tick = run_q && (div_q == DivLast);

`ifdef JTAG_DMI_HOST_IR_CACHE_EN
    logic [IrLength-1:0] ir_cache_q;
    logic                ir_cache_vld_q;

    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) begin
            ir_cache_q     <= '0;
            ir_cache_vld_q <= 1'b0;
        end else if (state_q == INIT) begin
            ir_cache_vld_q <= 1'b0;
        end else if (tick && tck_o && state_q == UPD_IR) begin
            ir_cache_q     <= ir_q;
            ir_cache_vld_q <= 1'b1;
        end
    end

    assign ir_hit = ir_cache_vld_q && (ir_cache_q == ir_q);
`else
    assign ir_hit = 1'b0;
`endif

    // State names the TAP state occupied during the current TCK cycle; the
    // state and its TMS/TDI are updated together on the falling TCK tick, so
    // TMS/TDI are stable across every rising edge.
    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q     <= INIT;
            run_q       <= 1'b1;
            div_q       <= '0;
            cnt_q       <= '0;
            tck_o       <= 1'b0;
            tms_o       <= 1'b1;
            tdi_o       <= 1'b0;
            req_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_dr_o    <= '0;
            ir_q        <= '0;
            ir_sh       <= '0;
            dr_q        <= '0;
            len_q       <= 6'd1;
            mask_q      <= '0;
        end else begin
            div_q <= (tick || !run_q) ? '0 : div_q + 1'b1;

            if (tick && !tck_o) begin
                tck_o <= 1'b1;
                if (state_q == SHIFT_DR && tdo_i) begin
                    rsp_dr_o <= rsp_dr_o | mask_q;
                end
            end else if (tick && tck_o) begin
                tck_o <= 1'b0;
                case (state_q)
                    INIT: begin
                        if (cnt_q == InitLast) begin
                            state_q     <= IDLE;
                            run_q       <= 1'b0;
                            req_ready_o <= 1'b1;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                            tms_o <= (cnt_q + 6'd1) != InitLast;
                        end
                    end
                    IDLE: begin
                        // Run-Test/Idle cycle of a scan (TMS=1 already set).
                        state_q <= ir_hit ? SEL_DR : SEL_DR_IR;
                        tms_o   <= !ir_hit;
                    end
                    SEL_DR_IR: begin state_q <= SEL_IR; tms_o <= 1'b0; end
                    SEL_IR:    begin state_q <= CAP_IR; tms_o <= 1'b0; end
                    CAP_IR: begin
                        state_q <= SHIFT_IR;
                        cnt_q   <= '0;
                        tdi_o   <= ir_q[0];
                        ir_sh   <= ir_q >> 1;
                        tms_o   <= (IrLast == 6'd0);
                    end
                    SHIFT_IR: begin
                        if (cnt_q == IrLast) begin
                            state_q <= EXIT1_IR;
                            tms_o   <= 1'b1;
                            tdi_o   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                            tdi_o <= ir_sh[0];
                            ir_sh <= ir_sh >> 1;
                            tms_o <= (cnt_q + 6'd1) == IrLast;
                        end
                    end
                    EXIT1_IR: begin state_q <= UPD_IR; tms_o <= 1'b1; end
                    UPD_IR:   begin state_q <= SEL_DR; tms_o <= 1'b0; end
                    SEL_DR:   begin state_q <= CAP_DR; tms_o <= 1'b0; end
                    CAP_DR: begin
                        state_q <= SHIFT_DR;
                        cnt_q   <= '0;
                        tdi_o   <= dr_q[0];
                        dr_q    <= dr_q >> 1;
                        mask_q  <= MaskLsb;
                        tms_o   <= (len_q == 6'd1);
                    end
                    SHIFT_DR: begin
                        if (cnt_q == len_q - 6'd1) begin
                            state_q <= EXIT1_DR;
                            tms_o   <= 1'b1;
                            tdi_o   <= 1'b0;
                        end else begin
                            cnt_q  <= cnt_q + 6'd1;
                            tdi_o  <= dr_q[0];
                            dr_q   <= dr_q >> 1;
                            mask_q <= mask_q << 1;
                            tms_o  <= (cnt_q + 6'd1) == (len_q - 6'd1);
                        end
                    end
                    EXIT1_DR: begin state_q <= UPD_DR; tms_o <= 1'b0; end
                    UPD_DR: begin
                        state_q     <= RESP;
                        run_q       <= 1'b0;
                        rsp_valid_o <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (!run_q) begin
                if (state_q == IDLE && req_valid_i && req_ready_o) begin
                    ir_q        <= req_ir_i;
                    dr_q        <= req_dr_i;
                    len_q       <= len_clamped;
                    req_ready_o <= 1'b0;
                    run_q       <= 1'b1;
                    tms_o       <= 1'b1;
                    rsp_dr_o    <= '0;
                end else if (state_q == RESP && rsp_ready_i) begin
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    state_q     <= IDLE;
                end
            end
        end
    end

endmodule

// File: doc/jtag_dmi_host.md
JTAG_DMI_HOST -- requirements
Module: jtag_dmi_host

Interface
REQ-001 SHALL have parameter IrLength, default 5, instruction register length in bits.
REQ-002 SHALL have parameter DrMaxLen, default 41, maximum DR scan length in bits.
REQ-003 SHALL have parameter ClkDiv, default 2, clk_i cycles per TCK half-period, legal range >=1.
REQ-004 SHALL have port clk_i  input  1  system clock; all internal state advances on its rising edge.
REQ-005 SHALL have port trst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid_i input 1 and req_ready_o output 1, forming the request handshake.
REQ-007 SHALL have ports req_ir_i input IrLength (instruction), req_dr_i input DrMaxLen (shift-in data), req_len_i input 6 (DR bit count).
REQ-008 SHALL have ports rsp_valid_o output 1, rsp_ready_i input 1, rsp_dr_o output DrMaxLen (captured TDO bits), forming the response handshake.
REQ-009 SHALL have ports tck_o, tms_o, tdi_o outputs 1 and tdo_i input 1, connecting to the target TAP.

Function
REQ-010 SHALL generate tck_o by toggling it every ClkDiv clk_i cycles while a scan is active; tck_o SHALL hold 0 when idle.
REQ-011 SHALL change tms_o and tdi_o only on clk_i cycles where tck_o falls (or while tck_o is low before the first rise), never on a rising TCK.
REQ-012 SHALL sample tdo_i on the clk_i cycle where tck_o rises.
REQ-013 SHALL accept a request when req_valid_i && req_ready_o; req_ready_o SHALL be 1 only in state IDLE with rsp_valid_o low.
REQ-014 SHALL latch req_ir_i, req_dr_i and req_len_i on acceptance; later input changes SHALL have no effect.
REQ-015 SHALL clamp req_len_i to 1..DrMaxLen: 0 is treated as 1, and values above DrMaxLen are treated as DrMaxLen.
REQ-016 SHALL implement the following states: INIT, IDLE, SEL_DR_IR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, UPD_IR, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, UPD_DR, RESP.
REQ-017 SHALL drive these TMS values per TCK cycle (rise-to-rise) from Run-Test/Idle: IR path 1,1,0,0, then IrLength shift cycles (TMS 0, last 1), then 1 (update); DR path 1,0,0, then len shift cycles (TMS 0, last 1), then 1 (update), then 0 (return to idle).
REQ-018 SHALL take the DR path directly after the IR update with TMS=1 (Update-IR to Select-DR), without passing through idle.
REQ-019 SHALL shift IR and DR data LSB first on tdi_o; tdi_o SHALL be 0 outside shift cycles.
REQ-020 SHALL assemble the len TDO bits sampled during SHIFT_DR into rsp_dr_o[len-1:0], first sample at bit 0; bits len..DrMaxLen-1 SHALL be 0.
REQ-021 SHALL enter RESP after the final idle TCK cycle completes, assert rsp_valid_o, and hold rsp_dr_o stable until rsp_valid_o && rsp_ready_i, then go to IDLE.
REQ-022 SHALL accept a new request no earlier than the cycle after the response handshake (no request/response overlap).

Reset
REQ-023 SHALL, while trst_ni is low, force tck_o=0, tms_o=1, tdi_o=0, req_ready_o=0, rsp_valid_o=0, rsp_dr_o=0, and state INIT.
REQ-024 SHALL, in INIT after reset release, issue 5 TCK cycles with TMS=1 then 1 TCK cycle with TMS=0 (Test-Logic-Reset then Run-Test/Idle), then enter IDLE.
REQ-025 SHALL abort any scan immediately on trst_ni assertion mid-operation, discarding the request with no response.

Configuration
REQ-026 SHALL, when macro JTAG_DMI_HOST_IR_CACHE_EN is defined, record the last IR value shifted and skip the IR path (going directly from idle via 1,0,0 into the DR path) when the latched req_ir_i equals that value.
REQ-027 SHALL invalidate the IR cache on reset and after INIT, so the first request always performs an IR scan.
REQ-028 SHALL, without JTAG_DMI_HOST_IR_CACHE_EN, perform the IR path on every request.

Verification
REQ-029 SHALL cover the reset sequence: release trst_ni -> exactly 5 TCK rises with tms_o=1, 1 with tms_o=0, then req_ready_o=1.
REQ-030 SHALL cover an IDCODE read: ir=5'h01, len=32, dr=0 against a TAP model with IdcodeValue 32'h00000001 -> rsp_dr_o=32'h00000001.
REQ-031 SHALL cover a DMI write: ir=5'h11, len=41, dr={7'h10,32'h1,2'b10} -> the TAP model DMI register receives 41'h04000000006 at Update-DR.
REQ-032 SHALL cover clamping: len=0 -> exactly one SHIFT_DR TCK cycle; len=63 -> 41 shift cycles.
REQ-033 SHALL cover back-pressure: rsp_ready_i=0 for 10 cycles -> rsp_valid_o and rsp_dr_o stable, req_ready_o=0.
REQ-034 SHALL cover the IR cache with the macro defined: two requests with ir=5'h11 -> the second has no SHIFT_IR cycles; without the macro, both have 5 SHIFT_IR cycles.
